// File: rtl/instr_fetch.sv
// Instruction fetch stage: loadable program memory, PC sequencing,
// each word held for HOLD_CYCLES cycles ahead of the simple_cpu CU.
module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS = 5,
  parameter int HOLD_CYCLES = 3,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   stall,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DONE
  } state_t;

  localparam int DEPTH = 2 ** PC_BITS;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [PC_BITS-1:0] PC_LAST = '1;

  state_t                 state;
  logic [CW-1:0]          hold_cnt;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic                   mem_we;
  logic                   hold_end;
  logic                   stop;

  assign mem_we = load_en && (state == IDLE || state == DONE);
  assign hold_end = (hold_cnt == HOLD_LAST) && !stall;
  assign stop = (instruction == HALT_WORD) || (pc == PC_LAST);

  // Program memory survives reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            pc    <= '0;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          instruction <= mem[pc];
          instr_valid <= 1'b1;
          hold_cnt    <= '0;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (hold_end) begin
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            if (stop) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end
          end else if (!stall) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state <= FETCH;
            pc    <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: each issued word run is popped
// from an expected queue and checked for value and hold length.
module tb_instr_fetch;

  localparam int HOLD = 3;
  localparam logic [19:0] NOP = 20'h00000;
  localparam logic [19:0] HALT = 20'hFFFFF;

  typedef struct {
    logic [19:0] w;
    int          n;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [19:0] load_data;
  logic        start;
  logic        stall;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  logic [19:0] mem_m [32];

  instr_fetch dut (
    .clk(clk),
    .rst(rst),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .start(start),
    .stall(stall),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc(pc),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run monitor: checks stability, run length, value and FETCH gap.
  int run_len = 0;
  int gap = 0;
  logic [19:0] cur;
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      run_len = 0;
      gap = 0;
    end else if (instr_valid) begin
      if (run_len == 0) begin
        cur = instruction;
        vectors++;
        if (gap !== 1) begin
          miscompares++;
          $display("FAIL fetch_gap: got %0d cycles, want 1", gap);
        end
      end else begin
        vectors++;
        if (instruction !== cur) begin
          miscompares++;
          $display("FAIL stable: got %h, want %h", instruction, cur);
        end
      end
      run_len++;
      gap = 0;
    end else begin
      vectors++;
      if (instruction !== NOP) begin
        miscompares++;
        $display("FAIL nop_idle: got %h, want %h", instruction, NOP);
      end
      if (run_len > 0) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_run: got %h x%0d, want none", cur, run_len);
        end else begin
          e = q.pop_front();
          if (cur !== e.w || run_len !== e.n) begin
            miscompares++;
            $display("FAIL run: got %h x%0d, want %h x%0d",
                     cur, run_len, e.w, e.n);
          end
        end
        run_len = 0;
      end
      if (busy) gap++;
      else gap = 0;
    end
  end

  task automatic push_prog();
    for (int i = 0; i < 32; i++) begin
      q.push_back('{w: mem_m[i], n: HOLD});
      if (mem_m[i] == HALT || i == 31) break;
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [19:0] d);
    @(posedge clk); #1;
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (instruction !== NOP || instr_valid !== 1'b0 || pc !== 5'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got ins=%h v=%b pc=%0d b=%b d=%b, want %h 0 0 0 0",
               instruction, instr_valid, pc, busy, done, NOP);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    load(5'd0, 20'h12345);
    load(5'd1, 20'h0ABCD);
    load(5'd2, HALT);
    push_prog();
    pulse_start();
    vectors++;
    if (busy !== 1'b1 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_fetch: got b=%b v=%b, want 1 0", busy, instr_valid);
    end
    wait_done(ok);
    vectors++;
    if (!ok || pc !== 5'd2 || instr_valid !== 1'b0 || busy !== 1'b0 ||
        q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_end: got ok=%b pc=%0d v=%b b=%b q=%0d, want 1 2 0 0 0",
               ok, pc, instr_valid, busy, q.size());
    end
  endtask

  task automatic test_no_halt();
    bit ok;
    bit went_back;
    logic [4:0] prev;
    for (int i = 0; i < 32; i++) load(5'(i), 20'h00011);
    push_prog();
    pulse_start();
    prev = 5'd0;
    went_back = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pc < prev) went_back = 1'b1;
      prev = pc;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    vectors++;
    if (!ok || went_back || pc !== 5'd31 || q.size() != 0) begin
      miscompares++;
      $display("FAIL no_halt: got ok=%b back=%b pc=%0d q=%0d, want 1 0 31 0",
               ok, went_back, pc, q.size());
    end
  endtask

  task automatic test_stall();
    bit ok;
    load(5'd0, 20'hABCDE);
    load(5'd1, HALT);
    q.push_back('{w: 20'hABCDE, n: HOLD + 4});
    q.push_back('{w: HALT, n: HOLD});
    pulse_start();
    repeat (2) @(posedge clk);
    #1 stall = 1'b1;
    repeat (4) @(posedge clk);
    #1 stall = 1'b0;
    vectors++;
    if (pc !== 5'd0 || instruction !== 20'hABCDE) begin
      miscompares++;
      $display("FAIL stall_hold: got pc=%0d ins=%h, want 0 abcde", pc, instruction);
    end
    wait_done(ok);
    vectors++;
    if (!ok || pc !== 5'd1 || q.size() != 0) begin
      miscompares++;
      $display("FAIL stall_end: got ok=%b pc=%0d q=%0d, want 1 1 0", ok, pc, q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    load(5'd0, 20'h12345);
    load(5'd1, 20'h0ABCD);
    load(5'd2, HALT);
    push_prog();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && pc === 5'd1) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got no word1, want word1 issuing");
    end
    #1 rst = 1'b0;
    #1;
    q.delete();
    vectors++;
    if (instruction !== NOP || instr_valid !== 1'b0 || busy !== 1'b0 ||
        pc !== 5'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got ins=%h v=%b b=%b pc=%0d d=%b, want %h 0 0 0 0",
               instruction, instr_valid, busy, pc, done, NOP);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    push_prog();
    pulse_start();
    wait_done(ok);
    vectors++;
    if (!ok || pc !== 5'd2 || q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_rerun: got ok=%b pc=%0d q=%0d, want 1 2 0", ok, pc, q.size());
    end
  endtask

  task automatic test_load_busy();
    bit ok;
    push_prog();
    pulse_start();
    @(posedge clk); #1;
    load_en = 1'b1;
    load_addr = 5'd0;
    load_data = 20'h55555;
    @(posedge clk); #1;
    load_en = 1'b0;
    wait_done(ok);
    push_prog();
    pulse_start();
    wait_done(ok);
    vectors++;
    if (!ok || q.size() != 0) begin
      miscompares++;
      $display("FAIL load_busy: got ok=%b q=%0d, want 1 0", ok, q.size());
    end
    @(posedge clk); #1;
    load_en = 1'b1;
    start = 1'b1;
    load_addr = 5'd0;
    load_data = 20'h55555;
    mem_m[0] = 20'h55555;
    push_prog();
    @(posedge clk); #1;
    load_en = 1'b0;
    start = 1'b0;
    wait_done(ok);
    vectors++;
    if (!ok || q.size() != 0 || pc !== 5'd2) begin
      miscompares++;
      $display("FAIL load_same_cycle: got ok=%b q=%0d pc=%0d, want 1 0 2",
               ok, q.size(), pc);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    push_prog();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && pc === 5'd1) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (!seen || pc !== 5'd1 || busy !== 1'b1 || instruction !== 20'h0ABCD) begin
      miscompares++;
      $display("FAIL start_busy: got seen=%b pc=%0d b=%b ins=%h, want 1 1 1 0abcd",
               seen, pc, busy, instruction);
    end
    wait_done(ok);
    push_prog();
    pulse_start();
    vectors++;
    if (!ok || done !== 1'b0 || pc !== 5'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart: got ok=%b d=%b pc=%0d b=%b, want 1 0 0 1",
               ok, done, pc, busy);
    end
    wait_done(ok);
    vectors++;
    if (!ok || q.size() != 0 || pc !== 5'd2) begin
      miscompares++;
      $display("FAIL restart_end: got ok=%b q=%0d pc=%0d, want 1 0 2",
               ok, q.size(), pc);
    end
  endtask

  initial begin
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    start = 1'b0;
    stall = 1'b0;
    test_reset();
    test_basic();
    test_no_halt();
    test_stall();
    test_reset_mid();
    test_load_busy();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
